commit_event_checker: RTL and testbench
=======================================

Name: commit_event_checker

Overview:
- Synthesizable, parametrised checker for architectural-state commit events.
- Snoops up to NUM_PORTS register-file/HI-LO write ports and filters them to value-changing events only.
- Queues the events in an internal FIFO and compares them in order against an expected-event stream, such as a ROM-fed answer list.
- Exposes sticky pass/fail status, a match counter and mismatch capture registers, so CPU self-test runs on FPGA need no simulator.

Parameters:
- NUM_PORTS, 2, number of snooped write ports (1..4).
- DATA_WIDTH, 32, width of a written value.
- IDX_WIDTH, 6, event index width. Indices 0-31 are GPRs, 32 is hi, 33 is lo; the rest are free.
- FIFO_DEPTH, 8, observed-event FIFO entries (power of 2, at least NUM_PORTS).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- clear, in, 1, synchronous pulse: return to reset state.
- wr_en, in, NUM_PORTS, per-port write strobe.
- wr_idx, in, NUM_PORTS*IDX_WIDTH, per-port index; port p occupies slice [p*IDX_WIDTH +: IDX_WIDTH].
- wr_data, in, NUM_PORTS*DATA_WIDTH, per-port write value; same slicing scheme.
- exp_valid, in, 1, expected event available.
- exp_idx, in, IDX_WIDTH, expected index.
- exp_data, in, DATA_WIDTH, expected value.
- exp_ready, out, 1, expected event consumed this cycle.
- match_count, out, 32, number of matched events.
- mismatch, out, 1, sticky fail flag.
- overflow, out, 1, sticky: an observed event was lost.
- err_idx_obs, out, IDX_WIDTH, observed index at the first mismatch.
- err_data_obs, out, DATA_WIDTH, observed value at the first mismatch.
- err_idx_exp, out, IDX_WIDTH, expected index at the first mismatch.
- err_data_exp, out, DATA_WIDTH, expected value at the first mismatch.
- fifo_level, out, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-low (rst_n). Reset and clear have identical effect, and clear overrides any same-cycle activity:
  - all outputs are 0;
  - the shadow state (2^IDX_WIDTH entries) is 0;
  - the FIFO is empty;
  - the FSM is in RUN.
- Filter:
  - A port produces an event only if wr_en=1, idx!=0, and wr_data differs from the shadow entry for idx.
  - The shadow entry is updated on every enabled write to a nonzero idx, whether or not it produced an event.
  - Writes to idx 0 are ignored entirely.
- Same-index collision: if several ports write the same idx in one cycle, only the highest-numbered port is considered (last-writer-wins). The shadow takes that value, and lower ports' writes to that idx are dropped before filtering.
- Enqueue order:
  - Events from one cycle are pushed in ascending port order, all in the same clock edge.
  - An event is visible at the FIFO head on the cycle after the write.
- Overflow:
  - If free entries are fewer than the number of events in a cycle, none of that cycle's events are pushed and overflow is set (sticky).
  - A same-cycle pop counts as freeing one entry.
  - The shadow still updates.
- FSM RUN:
  - exp_ready = exp_valid and FIFO non-empty.
  - On exp_ready, pop the head and compare both idx and data.
  - If both match, match_count increments (visible next cycle, saturating at 2^32-1).
  - Otherwise, capture head and expected fields into err_* and go to FAIL.
- FSM FAIL:
  - exp_ready=0 and mismatch=1.
  - Snooping and enqueue continue, and overflow can still set.
  - Leaves only on reset or clear.
- An expected event is never consumed without an observed event. exp_valid with an empty FIFO simply waits.
- Overall latency: a write on cycle N can be compared on cycle N+1 at the earliest; its match_count/mismatch update is visible on cycle N+2.
- Reset asserted mid-operation discards the FIFO and shadow immediately.

Test Plan:
1. Port0 writes idx 2 = 0x12345678, then idx 2 = 0x12345678 again; expected stream is {2, 0x12345678}. Required: exactly one event is produced, match_count=1, mismatch=0.
2. Port0 writes idx 5 = 0xA and port1 writes idx 5 = 0xB in the same cycle; expected stream is {5, 0xB}. Required: match_count=1, no further event, and the shadow for idx 5 holds 0xB (a later write of 0xB yields no event).
3. Port0 writes idx 3 = 1 and port1 writes idx 32 (hi) = 2 in one cycle; expected stream is {3,1}, {32,2}. Required: match_count=2 with the events in port order.
4. Write idx 4 = 0xFF while expected stream is {4, 0xFE}. Required: mismatch=1, err_idx_obs=4, err_data_obs=0xFF, err_idx_exp=4, err_data_exp=0xFE; exp_ready stays 0 afterwards; a clear pulse returns all outputs to 0.
5. With exp_valid=0 and FIFO_DEPTH=8, produce 9 distinct events. Required: fifo_level=8 and overflow=1; afterwards the 8 queued events still match in order.
6. Assert rst_n low with 3 events queued. Required: fifo_level=0 and match_count=0 immediately, before any clock edge.

Source files
------------

// File: rtl/commit_event_checker.sv
// Commit-event checker: filters snooped register writes down to value-changing events,
// queues them, and compares them in order against an expected-event stream.
module commit_event_checker #(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = 6,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clear,
   input  logic [NUM_PORTS-1:0]            wr_en,
   input  logic [NUM_PORTS*IDX_WIDTH-1:0]  wr_idx,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
   input  logic                            exp_valid,
   input  logic [IDX_WIDTH-1:0]            exp_idx,
   input  logic [DATA_WIDTH-1:0]           exp_data,
   output logic                            exp_ready,
   output logic [31:0]                     match_count,
   output logic                            mismatch,
   output logic                            overflow,
   output logic [IDX_WIDTH-1:0]            err_idx_obs,
   output logic [DATA_WIDTH-1:0]           err_data_obs,
   output logic [IDX_WIDTH-1:0]            err_idx_exp,
   output logic [DATA_WIDTH-1:0]           err_data_exp,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned LW  = PW + 1;
   localparam int unsigned NSH = 1 << IDX_WIDTH;

   typedef enum logic {
      S_RUN,
      S_FAIL
   } state_t;

   state_t r_state, w_state_nxt;

   logic [DATA_WIDTH-1:0] r_shadow    [NSH];
   logic [IDX_WIDTH-1:0]  r_fifo_idx  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [PW-1:0]         r_wptr, r_rptr;
   logic [LW-1:0]         r_level;
   logic [31:0]           r_match_count;
   logic                  r_overflow;
   logic [IDX_WIDTH-1:0]  r_err_idx_obs, r_err_idx_exp;
   logic [DATA_WIDTH-1:0] r_err_data_obs, r_err_data_exp;

   logic [IDX_WIDTH-1:0]  w_idx  [NUM_PORTS];
   logic [DATA_WIDTH-1:0] w_data [NUM_PORTS];
   logic [PW-1:0]         w_off  [NUM_PORTS];
   logic [NUM_PORTS-1:0]  w_keep, w_evt;
   logic [LW-1:0]         w_nevt, w_free;
   logic                  w_drop, w_push, w_pop, w_hit;
   logic [IDX_WIDTH-1:0]  w_head_idx;
   logic [DATA_WIDTH-1:0] w_head_data;

   // A port survives only if no higher-numbered port writes the same index this
   // cycle; each event's FIFO slot offset is the count of events on lower ports.
   always_comb begin
      w_keep = '0;
      w_evt  = '0;
      w_nevt = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         w_idx[p]  = wr_idx[p*IDX_WIDTH +: IDX_WIDTH];
         w_data[p] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
         w_off[p]  = '0;
      end
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         w_keep[p] = wr_en[p] && (w_idx[p] != '0);
         for (int unsigned q = p + 1; q < NUM_PORTS; q++) begin
            if (wr_en[q] && (w_idx[q] == w_idx[p])) w_keep[p] = 1'b0;
         end
         w_evt[p] = w_keep[p] && (w_data[p] != r_shadow[w_idx[p]]);
         w_off[p] = w_nevt[PW-1:0];
         if (w_evt[p]) w_nevt = w_nevt + LW'(1);
      end
   end

   always_comb begin
      w_head_idx  = r_fifo_idx[r_rptr];
      w_head_data = r_fifo_data[r_rptr];
      w_pop       = (r_state == S_RUN) && exp_valid && (r_level != '0) && !clear;
      w_hit       = (w_head_idx == exp_idx) && (w_head_data == exp_data);
      w_state_nxt = r_state;
      if (w_pop && !w_hit) w_state_nxt = S_FAIL;
      exp_ready   = w_pop;
      // A same-cycle pop frees one slot for this cycle's events.
      w_free      = LW'(FIFO_DEPTH) - r_level + LW'(w_pop);
      w_drop      = (w_nevt > w_free);
      w_push      = (w_nevt != '0) && !w_drop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_state <= S_RUN;
      else if (clear) r_state <= S_RUN;
      else            r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_level        <= '0;
         r_match_count  <= '0;
         r_overflow     <= 1'b0;
         r_err_idx_obs  <= '0;
         r_err_data_obs <= '0;
         r_err_idx_exp  <= '0;
         r_err_data_exp <= '0;
         for (int unsigned i = 0; i < NSH; i++) r_shadow[i] <= '0;
      end else if (clear) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_level        <= '0;
         r_match_count  <= '0;
         r_overflow     <= 1'b0;
         r_err_idx_obs  <= '0;
         r_err_data_obs <= '0;
         r_err_idx_exp  <= '0;
         r_err_data_exp <= '0;
         for (int unsigned i = 0; i < NSH; i++) r_shadow[i] <= '0;
      end else begin
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         if (w_push) r_wptr <= r_wptr + w_nevt[PW-1:0];
         r_level <= r_level + (w_push ? w_nevt : '0) - LW'(w_pop);
         if (w_drop) r_overflow <= 1'b1;
         if (w_pop && w_hit && (r_match_count != '1)) r_match_count <= r_match_count + 32'd1;
         if (w_pop && !w_hit) begin
            r_err_idx_obs  <= w_head_idx;
            r_err_data_obs <= w_head_data;
            r_err_idx_exp  <= exp_idx;
            r_err_data_exp <= exp_data;
         end
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_keep[p]) r_shadow[w_idx[p]] <= w_data[p];
         end
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers above.
   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_evt[p]) begin
               r_fifo_idx[r_wptr + w_off[p]]  <= w_idx[p];
               r_fifo_data[r_wptr + w_off[p]] <= w_data[p];
            end
         end
      end
   end

   assign match_count  = r_match_count;
   assign mismatch     = (r_state == S_FAIL);
   assign overflow     = r_overflow;
   assign err_idx_obs  = r_err_idx_obs;
   assign err_data_obs = r_err_data_obs;
   assign err_idx_exp  = r_err_idx_exp;
   assign err_data_exp = r_err_data_exp;
   assign fifo_level   = r_level;

endmodule

// File: tb/tb_commit_event_checker.sv
// Bench for commit_event_checker: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_commit_event_checker;
   localparam int NP = 2;
   localparam int DW = 32;
   localparam int IW = 6;
   localparam int FD = 8;

   logic            clk = 1'b0;
   logic            rst_n, clear;
   logic [NP-1:0]   wr_en;
   logic [NP*IW-1:0] wr_idx;
   logic [NP*DW-1:0] wr_data;
   logic            exp_valid;
   logic [IW-1:0]   exp_idx;
   logic [DW-1:0]   exp_data;
   logic            exp_ready;
   logic [31:0]     match_count;
   logic            mismatch, overflow;
   logic [IW-1:0]   err_idx_obs, err_idx_exp;
   logic [DW-1:0]   err_data_obs, err_data_exp;
   logic [$clog2(FD):0] fifo_level;

   commit_event_checker #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .exp_valid(exp_valid), .exp_idx(exp_idx), .exp_data(exp_data),
      .exp_ready(exp_ready), .match_count(match_count),
      .mismatch(mismatch), .overflow(overflow),
      .err_idx_obs(err_idx_obs), .err_data_obs(err_data_obs),
      .err_idx_exp(err_idx_exp), .err_data_exp(err_data_exp),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] en, input logic [IW-1:0] i0, input logic [DW-1:0] d0,
                        input logic [IW-1:0] i1, input logic [DW-1:0] d1,
                        input logic ev, input logic [IW-1:0] ei, input logic [DW-1:0] ed);
      wr_en     = en;
      wr_idx    = {i1, i0};
      wr_data   = {d1, d0};
      exp_valid = ev;
      exp_idx   = ei;
      exp_data  = ed;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0);
      next_cycle();
      clear = 1'b0;
   endtask

   // Directed vectors: inputs for one cycle plus outputs expected during that cycle.
   typedef struct {
      logic [1:0]    en;
      logic [IW-1:0] i0;
      logic [DW-1:0] d0;
      logic [IW-1:0] i1;
      logic [DW-1:0] d1;
      logic          ev;
      logic [IW-1:0] ei;
      logic [DW-1:0] ed;
      logic          rdy;
      int            lvl;
      int            cnt;
   } vec_t;

   function automatic vec_t mk(logic [1:0] en, logic [IW-1:0] i0, logic [DW-1:0] d0,
                               logic [IW-1:0] i1, logic [DW-1:0] d1, logic ev,
                               logic [IW-1:0] ei, logic [DW-1:0] ed,
                               logic rdy, int lvl, int cnt);
      vec_t v;
      v.en = en; v.i0 = i0; v.d0 = d0; v.i1 = i1; v.d1 = d1;
      v.ev = ev; v.ei = ei; v.ed = ed; v.rdy = rdy; v.lvl = lvl; v.cnt = cnt;
      return v;
   endfunction

   // Reference model: the observed-event queue and per-index last value.
   typedef struct {
      logic [IW-1:0] idx;
      logic [DW-1:0] data;
   } ev_t;

   ev_t           mq[$];
   logic [DW-1:0] msh [64];
   longint        mcnt;
   bit            mfail, movf;
   logic [IW-1:0] me_io, me_ie;
   logic [DW-1:0] me_do, me_de;

   task automatic m_reset();
      mq.delete();
      foreach (msh[k]) msh[k] = '0;
      mcnt = 0; mfail = 0; movf = 0;
      me_io = '0; me_ie = '0; me_do = '0; me_de = '0;
   endtask

   task automatic m_step(input bit clr, input bit rdy);
      logic [DW-1:0] lastw [int];
      int            lastp [int];
      ev_t           evs[$];
      ev_t           h;
      if (clr) begin
         m_reset();
         return;
      end
      if (rdy) begin
         h = mq.pop_front();
         if (h.idx == exp_idx && h.data == exp_data) begin
            if (mcnt < 64'hFFFF_FFFF) mcnt++;
         end else begin
            mfail = 1;
            me_io = h.idx; me_do = h.data; me_ie = exp_idx; me_de = exp_data;
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (wr_en[p] && wr_idx[p*IW +: IW] != 0) begin
            lastw[int'(wr_idx[p*IW +: IW])] = wr_data[p*DW +: DW];
            lastp[int'(wr_idx[p*IW +: IW])] = p;
         end
      end
      for (int p = 0; p < NP; p++) begin
         int k;
         k = int'(wr_idx[p*IW +: IW]);
         if (wr_en[p] && k != 0 && lastp[k] == p && wr_data[p*DW +: DW] != msh[k]) begin
            h.idx = wr_idx[p*IW +: IW];
            h.data = wr_data[p*DW +: DW];
            evs.push_back(h);
         end
      end
      if (evs.size() > FD - mq.size()) movf = 1;
      else foreach (evs[j]) mq.push_back(evs[j]);
      foreach (lastw[k]) msh[k] = lastw[k];
   endtask

   task automatic random_phase(input int ncyc, input bit corrupt);
      int pool[7] = '{0, 1, 2, 3, 5, 32, 33};
      bit clr, rdy, ev;
      logic [1:0] en;
      logic [IW-1:0] i0, i1, ei;
      logic [DW-1:0] d0, d1, ed;
      for (int c = 0; c < ncyc; c++) begin
         clr = ($urandom_range(0, 299) == 0);
         en  = 2'($urandom_range(0, 3));
         i0  = IW'(pool[$urandom_range(0, 6)]);
         i1  = IW'(pool[$urandom_range(0, 6)]);
         d0  = DW'($urandom_range(0, 3));
         d1  = DW'($urandom_range(0, 3));
         ev  = ($urandom_range(0, 2) != 0);
         if (mq.size() > 0) begin
            ei = mq[0].idx;
            ed = mq[0].data;
            if (corrupt && $urandom_range(0, 149) == 0) ed = ed ^ 32'h1;
         end else begin
            ei = IW'($urandom_range(0, 63));
            ed = DW'($urandom_range(0, 3));
         end
         drive(en, i0, d0, i1, d1, ev, ei, ed);
         clear = clr;
         #3;
         rdy = !clr && !mfail && ev && (mq.size() > 0);
         chk("rnd exp_ready", 64'(exp_ready), 64'(rdy));
         chk("rnd fifo_level", 64'(fifo_level), 64'(mq.size()));
         chk("rnd match_count", 64'(match_count), 64'(mcnt));
         chk("rnd mismatch", 64'(mismatch), 64'(mfail));
         chk("rnd overflow", 64'(overflow), 64'(movf));
         if (mfail) begin
            chk("rnd err_idx_obs", 64'(err_idx_obs), 64'(me_io));
            chk("rnd err_data_obs", 64'(err_data_obs), 64'(me_do));
            chk("rnd err_idx_exp", 64'(err_idx_exp), 64'(me_ie));
            chk("rnd err_data_exp", 64'(err_data_exp), 64'(me_de));
         end
         m_step(clr, rdy);
         next_cycle();
         clear = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      rst_n = 1'b0;
      clear = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0);
      #12;
      chk("reset exp_ready", 64'(exp_ready), 0);
      chk("reset match_count", 64'(match_count), 0);
      chk("reset mismatch", 64'(mismatch), 0);
      chk("reset overflow", 64'(overflow), 0);
      chk("reset fifo_level", 64'(fifo_level), 0);
      chk("reset err_data_obs", 64'(err_data_obs), 0);
      next_cycle();
      rst_n = 1'b1;

      // Duplicate write filtered; same-index collision; two ports in port order; idx 0 ignored.
      tbl.push_back(mk(2'b01, 2, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(2'b01, 2, 32'h12345678, 0, 0, 1, 2, 32'h12345678, 1, 1, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 2, 32'h12345678, 0, 0, 1));
      tbl.push_back(mk(2'b11, 5, 32'hA, 5, 32'hB, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(2'b10, 0, 0, 5, 32'hB, 1, 5, 32'hB, 1, 1, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 5, 32'hB, 0, 0, 2));
      tbl.push_back(mk(2'b11, 3, 32'h1, 32, 32'h2, 0, 0, 0, 0, 0, 2));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 3, 32'h1, 1, 2, 2));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 32, 32'h2, 1, 1, 3));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
      tbl.push_back(mk(2'b11, 0, 32'h55, 0, 32'h66, 1, 0, 32'h55, 0, 0, 4));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 4));
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].i0, tbl[i].d0, tbl[i].i1, tbl[i].d1,
               tbl[i].ev, tbl[i].ei, tbl[i].ed);
         #3;
         chk($sformatf("vec%0d exp_ready", i), 64'(exp_ready), 64'(tbl[i].rdy));
         chk($sformatf("vec%0d fifo_level", i), 64'(fifo_level), 64'(tbl[i].lvl));
         chk($sformatf("vec%0d match_count", i), 64'(match_count), 64'(tbl[i].cnt));
         chk($sformatf("vec%0d mismatch", i), 64'(mismatch), 0);
         next_cycle();
      end

      // Mismatch capture, FAIL holds exp_ready low, clear recovers.
      drive(2'b01, 4, 32'hFF, 0, 0, 1'b0, 0, 0);
      next_cycle();
      drive(2'b01, 6, 32'h1, 0, 0, 1'b1, 4, 32'hFE);
      #3;
      chk("mm exp_ready before compare", 64'(exp_ready), 1);
      next_cycle();
      drive(2'b00, 0, 0, 0, 0, 1'b1, 4, 32'hFE);
      #3;
      chk("mm mismatch", 64'(mismatch), 1);
      chk("mm err_idx_obs", 64'(err_idx_obs), 4);
      chk("mm err_data_obs", 64'(err_data_obs), 64'h FF);
      chk("mm err_idx_exp", 64'(err_idx_exp), 4);
      chk("mm err_data_exp", 64'(err_data_exp), 64'hFE);
      chk("mm exp_ready in fail", 64'(exp_ready), 0);
      chk("mm fifo_level", 64'(fifo_level), 1);
      chk("mm match_count held", 64'(match_count), 4);
      next_cycle();
      #3;
      chk("mm exp_ready later", 64'(exp_ready), 0);
      chk("mm mismatch sticky", 64'(mismatch), 1);
      next_cycle();
      clear_pulse();
      #3;
      chk("clr match_count", 64'(match_count), 0);
      chk("clr mismatch", 64'(mismatch), 0);
      chk("clr fifo_level", 64'(fifo_level), 0);
      chk("clr err_idx_obs", 64'(err_idx_obs), 0);
      chk("clr err_data_obs", 64'(err_data_obs), 0);
      chk("clr err_idx_exp", 64'(err_idx_exp), 0);
      chk("clr err_data_exp", 64'(err_data_exp), 0);
      chk("clr exp_ready", 64'(exp_ready), 0);
      next_cycle();

      // Nine events into an eight-entry FIFO with no consumer.
      for (int i = 0; i < 9; i++) begin
         drive(2'b01, IW'(i + 1), DW'(i + 1), 0, 0, 1'b0, 0, 0);
         next_cycle();
      end
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0);
      #3;
      chk("ovf fifo_level", 64'(fifo_level), FD);
      chk("ovf overflow", 64'(overflow), 1);
      next_cycle();
      for (int i = 0; i < 8; i++) begin
         drive(2'b00, 0, 0, 0, 0, 1'b1, IW'(i + 1), DW'(i + 1));
         #3;
         chk($sformatf("ovf drain%0d exp_ready", i), 64'(exp_ready), 1);
         next_cycle();
      end
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0);
      #3;
      chk("ovf drained match_count", 64'(match_count), 8);
      chk("ovf drained level", 64'(fifo_level), 0);
      chk("ovf drained mismatch", 64'(mismatch), 0);
      chk("ovf sticky", 64'(overflow), 1);
      next_cycle();

      // Asynchronous reset with three events queued.
      clear_pulse();
      drive(2'b01, 9, 32'h7, 0, 0, 1'b0, 0, 0);
      next_cycle();
      drive(2'b11, 10, 32'h1, 11, 32'h2, 1'b1, 9, 32'h7);
      next_cycle();
      drive(2'b01, 12, 32'h3, 0, 0, 1'b0, 0, 0);
      next_cycle();
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0);
      #3;
      chk("rst pre level", 64'(fifo_level), 3);
      chk("rst pre count", 64'(match_count), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst async level", 64'(fifo_level), 0);
      chk("rst async count", 64'(match_count), 0);
      next_cycle();
      rst_n = 1'b1;
      drive(2'b01, 10, 32'h1, 0, 0, 1'b0, 0, 0);
      next_cycle();
      drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0);
      #3;
      chk("rst shadow discarded", 64'(fifo_level), 1);
      next_cycle();

      // Randomized traffic against the model: clean stream, then occasional corruption.
      clear_pulse();
      m_reset();
      random_phase(1500, 1'b0);
      clear_pulse();
      m_reset();
      random_phase(1500, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
